fpu_io_sequencer: RTL and testbench
===================================

Name: fpu_io_sequencer

Overview:
Parametrised pin-level front/back end for an arithmetic core behind a narrow IO bus. It assembles an opcode and NUM_OPS operands of DATA_W bits from IO_W-bit input beats, issues them to the compute unit with a start pulse, and waits for done or a timeout. It then streams the result back in IO_W-bit beats with valid/ready backpressure. It sits between the chip top-level pins and the FPU core, and supersedes fixed-width single-cycle loading.

Parameters:
IO_W, 12, width of input/output data beats
DATA_W, 32, operand and result width
OP_W, 4, opcode width (OP_W <= IO_W)
NUM_OPS, 2, operands per transaction (>= 1)
TIMEOUT, 255, max cycles in WAIT before error (>= 1)
Derived (localparam): CHUNKS = ceil(DATA_W/IO_W); BEATS = NUM_OPS*CHUNKS

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  sequencer accepts input beat
in_data  input  IO_W  input beat
op  output  OP_W  latched opcode to core
operands  output  NUM_OPS*DATA_W  operand k at bits [k*DATA_W +: DATA_W]
start  output  1  one-cycle issue pulse to core
calc_done  input  1  core result valid (level or pulse)
calc_result  input  DATA_W  core result
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  IO_W  output beat
out_last  output  1  final beat of result
out_err  output  1  timeout flag, held for all beats of that result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; op, operands, result reg, counters = 0; start, out_valid, out_last, out_err = 0; in_ready=1.
- Handshake: a beat transfers on a rising edge with valid&&ready. Data is sampled only on transfer. out_data/out_last/out_err are stable while out_valid&&!out_ready.
- IDLE: in_ready=1. Transfer -> op <= in_data[OP_W-1:0], beat_cnt<=0, -> LOAD.
- LOAD: in_ready=1. Each transfer writes chunk (beat_cnt % CHUNKS) of operand (beat_cnt / CHUNKS), LSB chunk first, operand 0 first. In the last chunk, bits above DATA_W are ignored. On transfer with beat_cnt==BEATS-1 -> ISSUE.
- ISSUE: in_ready=0; start=1 for exactly this cycle; op/operands stable from here until the next IDLE opcode beat. -> WAIT, tmo_cnt<=0.
- WAIT: in_ready=0. calc_done sampled high -> result<=calc_result, out_err<=0, -> SEND. Otherwise tmo_cnt++. If tmo_cnt==TIMEOUT-1 and no done -> result<=all ones, out_err<=1, -> SEND. A calc_done in the same cycle as timeout wins (no error). calc_done in ISSUE is ignored. The first WAIT cycle can complete, giving start-to-capture latency of 1 cycle.
- SEND: out_valid=1. out_data = chunk out_cnt of result, zero-padded above DATA_W. out_last = (out_cnt==CHUNKS-1). On transfer of the last beat -> IDLE (out_valid=0, out_err cleared the next cycle); otherwise out_cnt++. in_ready=0 throughout; no overlap with the next transaction.
- Minimum turnaround, no stalls: 1 + BEATS input cycles, 1 ISSUE, >=1 WAIT, CHUNKS output.
- Reset mid-transaction: immediate return to reset values; partial operands are discarded.
- All counters are sized $clog2 of their bound +1 and have no wrap-around beyond the defined limits.

Decomposition:
- Package fpu_io_pkg holds: typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, SEND} seq_state_t, and a ceil-div function used for CHUNKS.
- One sub-module is natural: fpu_io_serializer (SEND path: result reg, out_cnt, padding, valid/ready). The load/issue/wait FSM stays in the top.

Test Plan:
- Defaults; beats 0x003, 0x000, 0x800, 0x03F, 0x000, 0x000, 0x040 -> op=4'h3, operands[31:0]=0x3F800000, operands[63:32]=0x40000000, start high exactly 1 cycle after the 7th transfer.
- calc_done 3 cycles after start with calc_result=0x40400000, out_ready=1 -> out beats 0x000, 0x400, 0x040; out_last only on the 3rd; out_err=0; busy falls after the last beat.
- Same transaction with out_ready toggled 0/1 every cycle -> each beat held stable while stalled, exactly 3 transfers, correct order.
- No calc_done, TIMEOUT=8 -> SEND entered 8 cycles after start with beats 0xFFF, 0xFFF, 0x0FF and out_err=1 on all beats. Repeat with done on cycle 8 -> out_err=0.
- Assert reset low for 1 cycle after the 4th input beat -> all outputs at reset values immediately; a fresh 7-beat transaction then completes correctly.
- DATA_W=10, IO_W=4, NUM_OPS=3 -> CHUNKS=3, 10 input beats. Top 2 bits of each operand's last input chunk are ignored; the result's last output beat is zero-padded in bits [3:2].

Source files
------------

// File: rtl/fpu_io_pkg.sv
// Shared types and helpers for the FPU IO sequencer.
//   seq_state_t : sequencer FSM states
//   ceil_div    : integer ceiling division, used to size chunk counts
package fpu_io_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT,
      SEND
   } seq_state_t;

   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/fpu_io_serializer.sv
// Result serializer: holds one result and streams it out as IO_W-bit beats,
// least-significant chunk first, with valid/ready backpressure.
// Ports:
//   clock, reset          : clock and asynchronous active-low reset
//   load, load_value      : capture a new result (only while not streaming)
//   load_err              : error flag travelling with that result
//   finish                : pulses on the transfer of the final beat
//   out_valid/out_ready   : output handshake
//   out_data              : current beat, zero-padded above DATA_W
//   out_last, out_err     : final-beat marker and error flag for the current beat
module fpu_io_serializer #(
   parameter int unsigned IO_W   = 12,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_value,
   input  logic              load_err,
   output logic              finish,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IO_W-1:0]   out_data,
   output logic              out_last,
   output logic              out_err
);
   import fpu_io_pkg::*;

   localparam int unsigned CHUNKS = ceil_div(DATA_W, IO_W);
   localparam int unsigned OUT_W  = $clog2(CHUNKS + 1);

   logic [DATA_W-1:0]      result_q, result_d;
   logic [OUT_W-1:0]       out_cnt_q, out_cnt_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic [CHUNKS*IO_W-1:0] padded;
   logic                   xfer;

   always_comb begin
      padded = '0;
      padded[DATA_W-1:0] = result_q;
   end

   assign out_valid = valid_q;
   assign out_err   = err_q;
   assign out_last  = valid_q & (out_cnt_q == OUT_W'(CHUNKS - 1));
   // Everything is registered, so the beat stays stable while stalled.
   assign out_data  = IO_W'(padded >> (IO_W * out_cnt_q));
   assign xfer      = valid_q & out_ready;
   assign finish    = xfer & out_last;

   always_comb begin
      result_d  = result_q;
      out_cnt_d = out_cnt_q;
      valid_d   = valid_q;
      err_d     = err_q;
      if (load) begin
         result_d  = load_value;
         err_d     = load_err;
         valid_d   = 1'b1;
         out_cnt_d = '0;
      end else if (finish) begin
         valid_d   = 1'b0;
         err_d     = 1'b0;
         out_cnt_d = '0;
      end else if (xfer) begin
         out_cnt_d = out_cnt_q + OUT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         result_q  <= '0;
         out_cnt_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         result_q  <= result_d;
         out_cnt_q <= out_cnt_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: rtl/fpu_io_sequencer.sv
// Pin-level front/back end for an arithmetic core behind a narrow IO bus.
// Collects an opcode beat plus NUM_OPS operands of DATA_W bits (CHUNKS beats
// each, LSB chunk first), pulses start, waits for calc_done or a timeout, then
// streams the result back through fpu_io_serializer.
// Ports:
//   clock, reset                  : clock and asynchronous active-low reset
//   in_valid/in_ready/in_data     : input beat handshake
//   op, operands                  : latched opcode and operands to the core
//   start                         : one-cycle issue pulse
//   calc_done, calc_result        : core completion and result
//   out_valid/out_ready/out_data  : output beat handshake
//   out_last, out_err             : final-beat marker and timeout flag
//   busy                          : high whenever not idle
module fpu_io_sequencer #(
   parameter int unsigned IO_W    = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IO_W-1:0]           in_data,
   output logic [OP_W-1:0]           op,
   output logic [NUM_OPS*DATA_W-1:0] operands,
   output logic                      start,
   input  logic                      calc_done,
   input  logic [DATA_W-1:0]         calc_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IO_W-1:0]           out_data,
   output logic                      out_last,
   output logic                      out_err,
   output logic                      busy
);
   import fpu_io_pkg::*;

   localparam int unsigned CHUNKS = ceil_div(DATA_W, IO_W);
   localparam int unsigned BEATS  = NUM_OPS * CHUNKS;
   localparam int unsigned BEAT_W = $clog2(BEATS + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

   seq_state_t                state_q, state_d;
   logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
   logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic [OP_W-1:0]           op_q, op_d;
   logic [NUM_OPS*DATA_W-1:0] operands_q, operands_d;

   logic [NUM_OPS*DATA_W-1:0] load_mask;
   logic [NUM_OPS*DATA_W-1:0] load_bits;

   logic              ser_load;
   logic [DATA_W-1:0] ser_value;
   logic              ser_err;
   logic              ser_finish;

   // Operand bit (k, b) lives in beat k*CHUNKS + b/IO_W at in_data[b % IO_W];
   // in_data bits beyond DATA_W in an operand's last beat map to nothing.
   for (genvar k = 0; k < NUM_OPS; k++) begin : g_opnd
      for (genvar b = 0; b < DATA_W; b++) begin : g_bit
         assign load_mask[k*DATA_W+b] = (beat_cnt_q == BEAT_W'(k*CHUNKS + b/IO_W));
         assign load_bits[k*DATA_W+b] = in_data[b%IO_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      op_d       = op_q;
      operands_d = operands_q;
      in_ready   = 1'b0;
      start      = 1'b0;
      ser_load   = 1'b0;
      ser_value  = '0;
      ser_err    = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               op_d       = in_data[OP_W-1:0];
               beat_cnt_d = '0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               operands_d = (operands_q & ~load_mask) | (load_bits & load_mask);
               if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                  state_d = ISSUE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         ISSUE: begin
            // calc_done is deliberately not looked at here.
            start     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (calc_done) begin
               // Done beats a simultaneous timeout.
               ser_load  = 1'b1;
               ser_value = calc_result;
               state_d   = SEND;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               ser_load  = 1'b1;
               ser_value = '1;
               ser_err   = 1'b1;
               state_d   = SEND;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         SEND: begin
            if (ser_finish) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         op_q       <= '0;
         operands_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         op_q       <= op_d;
         operands_q <= operands_d;
      end
   end

   assign op       = op_q;
   assign operands = operands_q;
   assign busy     = (state_q != IDLE);

   fpu_io_serializer #(
      .IO_W   (IO_W),
      .DATA_W (DATA_W)
   ) u_serializer (
      .clock      (clock),
      .reset      (reset),
      .load       (ser_load),
      .load_value (ser_value),
      .load_err   (ser_err),
      .finish     (ser_finish),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_err    (out_err)
   );

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Bench for fpu_io_sequencer: instance A (12-bit IO, 32-bit data, 2 operands,
// timeout 8) and instance B (4-bit IO, 10-bit data, 3 operands, timeout 4).
module tb_fpu_io_sequencer;

   localparam int A_IO = 12, A_DW = 32, A_TMO = 8, A_CH = (A_DW + A_IO - 1) / A_IO;
   localparam int B_IO = 4,  B_DW = 10, B_TMO = 4, B_CH = (B_DW + B_IO - 1) / B_IO;

   logic clock, reset;
   int   checks, errors;

   logic        a_in_valid, a_in_ready, a_start, a_calc_done;
   logic        a_out_valid, a_out_ready, a_out_last, a_out_err, a_busy;
   logic [11:0] a_in_data, a_out_data;
   logic [3:0]  a_op;
   logic [63:0] a_operands;
   logic [31:0] a_calc_result;

   logic        b_in_valid, b_in_ready, b_start, b_calc_done;
   logic        b_out_valid, b_out_ready, b_out_last, b_out_err, b_busy;
   logic [3:0]  b_in_data, b_out_data, b_op;
   logic [29:0] b_operands;
   logic [9:0]  b_calc_result;

   fpu_io_sequencer #(.IO_W(12), .DATA_W(32), .OP_W(4), .NUM_OPS(2), .TIMEOUT(8)) dut_a (
      .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .op(a_op), .operands(a_operands), .start(a_start),
      .calc_done(a_calc_done), .calc_result(a_calc_result), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
      .out_err(a_out_err), .busy(a_busy));

   fpu_io_sequencer #(.IO_W(4), .DATA_W(10), .OP_W(4), .NUM_OPS(3), .TIMEOUT(4)) dut_b (
      .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .op(b_op), .operands(b_operands), .start(b_start),
      .calc_done(b_calc_done), .calc_result(b_calc_result), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
      .out_err(b_out_err), .busy(b_busy));

   always #5 clock = ~clock;

   // dly: WAIT cycle (1-based) in which calc_done pulses; 0 = pulse during ISSUE only
   // (must be ignored); anything above the timeout = never.
   task automatic run_a(input logic [3:0] opc, input logic [31:0] o0, input logic [31:0] o1,
                        input int dly, input logic [31:0] res, input int rmode,
                        input bit junk, input bit gaps);
      logic [11:0] beats[$];
      logic [31:0] opv[2];
      logic [35:0] wide, opad;
      logic [31:0] exp_res;
      logic [11:0] exp_beat;
      logic        exp_err;
      int          send_at, idx, cyc;
      opv[0] = o0; opv[1] = o1;
      beats.push_back({(junk ? 8'($urandom) : 8'h00), opc});
      for (int k = 0; k < 2; k++) begin
         wide = {(junk ? 4'($urandom) : 4'h0), opv[k]};
         for (int c = 0; c < A_CH; c++) beats.push_back(wide[c*A_IO +: A_IO]);
      end
      if (dly >= 1 && dly <= A_TMO) begin
         exp_res = res; exp_err = 1'b0; send_at = dly + 1;
      end else begin
         exp_res = '1; exp_err = 1'b1; send_at = A_TMO + 1;
      end
      opad = {4'h0, exp_res};

      foreach (beats[i]) begin
         if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
               a_in_valid = 1'b0; a_in_data = 12'($urandom); @(negedge clock);
            end
         end
         checks++;
         if (a_in_ready !== 1'b1) begin
            errors++; $display("FAIL a_in_ready beat %0d: got %b want 1", i, a_in_ready);
         end
         a_in_valid = 1'b1; a_in_data = beats[i];
         @(negedge clock);
      end
      a_in_valid = 1'b0;

      checks++;
      if ({a_start, a_in_ready, a_busy, a_out_valid} !== 4'b1010) begin
         errors++;
         $display("FAIL a_issue: got start=%b in_ready=%b busy=%b out_valid=%b want 1 0 1 0",
                  a_start, a_in_ready, a_busy, a_out_valid);
      end
      checks++;
      if (a_op !== opc || a_operands !== {o1, o0}) begin
         errors++;
         $display("FAIL a_operands: got op=%h opnds=%h want op=%h opnds=%h",
                  a_op, a_operands, opc, {o1, o0});
      end
      a_calc_done = (dly == 0); a_calc_result = 32'($urandom);
      for (int w = 1; w < send_at; w++) begin
         @(negedge clock);
         checks++;
         if ({a_start, a_out_valid, a_busy, a_in_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL a_wait cycle %0d: got start=%b out_valid=%b busy=%b in_ready=%b",
                     w, a_start, a_out_valid, a_busy, a_in_ready);
         end
         a_calc_done   = (w == dly);
         a_calc_result = (w == dly) ? res : 32'($urandom);
      end
      @(negedge clock);
      a_calc_done = 1'b0;

      idx = 0; cyc = 0;
      while (idx < A_CH && cyc < 40) begin
         exp_beat = opad[idx*A_IO +: A_IO];
         checks++;
         if ({a_out_valid, a_out_data, a_out_last, a_out_err, a_in_ready} !==
             {1'b1, exp_beat, (idx == A_CH - 1), exp_err, 1'b0}) begin
            errors++;
            $display("FAIL a_send beat %0d: got v=%b d=%h l=%b e=%b ir=%b want v=1 d=%h l=%b e=%b",
                     idx, a_out_valid, a_out_data, a_out_last, a_out_err, a_in_ready,
                     exp_beat, (idx == A_CH - 1), exp_err);
         end
         case (rmode)
            0:       a_out_ready = 1'b1;
            1:       a_out_ready = ((cyc % 2) == 1);
            default: a_out_ready = 1'($urandom);
         endcase
         if (a_out_ready) idx++;
         @(negedge clock);
         cyc++;
      end
      a_out_ready = 1'b0;
      checks++;
      if (idx != A_CH) begin
         errors++; $display("FAIL a_send_bound: got %0d beats want %0d", idx, A_CH);
      end
      checks++;
      if ({a_out_valid, a_out_last, a_out_err, a_busy, a_in_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL a_post: got v=%b l=%b e=%b busy=%b ir=%b want 0 0 0 0 1",
                  a_out_valid, a_out_last, a_out_err, a_busy, a_in_ready);
      end
      checks++;
      if (a_op !== opc || a_operands !== {o1, o0}) begin
         errors++;
         $display("FAIL a_hold: got op=%h opnds=%h want op=%h opnds=%h",
                  a_op, a_operands, opc, {o1, o0});
      end
   endtask

   task automatic run_b(input logic [3:0] opc, input logic [29:0] opnds, input int dly,
                        input logic [9:0] res);
      logic [3:0]  beats[$];
      logic [11:0] wide, opad;
      logic [9:0]  exp_res;
      logic [3:0]  exp_beat;
      logic        exp_err;
      int          send_at, idx, cyc;
      beats.push_back(opc);
      for (int k = 0; k < 3; k++) begin
         wide = {2'($urandom), opnds[k*B_DW +: B_DW]};
         for (int c = 0; c < B_CH; c++) beats.push_back(wide[c*B_IO +: B_IO]);
      end
      if (dly >= 1 && dly <= B_TMO) begin
         exp_res = res; exp_err = 1'b0; send_at = dly + 1;
      end else begin
         exp_res = '1; exp_err = 1'b1; send_at = B_TMO + 1;
      end
      opad = {2'b00, exp_res};

      foreach (beats[i]) begin
         b_in_valid = 1'b1; b_in_data = beats[i];
         @(negedge clock);
      end
      b_in_valid = 1'b0;
      checks++;
      if (b_start !== 1'b1 || b_op !== opc || b_operands !== opnds) begin
         errors++;
         $display("FAIL b_issue: got start=%b op=%h opnds=%h want 1 %h %h",
                  b_start, b_op, b_operands, opc, opnds);
      end
      for (int w = 1; w < send_at; w++) begin
         @(negedge clock);
         b_calc_done   = (w == dly);
         b_calc_result = (w == dly) ? res : 10'($urandom);
      end
      @(negedge clock);
      b_calc_done = 1'b0;

      idx = 0; cyc = 0;
      while (idx < B_CH && cyc < 40) begin
         exp_beat = opad[idx*B_IO +: B_IO];
         checks++;
         if ({b_out_valid, b_out_data, b_out_last, b_out_err} !==
             {1'b1, exp_beat, (idx == B_CH - 1), exp_err}) begin
            errors++;
            $display("FAIL b_send beat %0d: got v=%b d=%h l=%b e=%b want v=1 d=%h l=%b e=%b",
                     idx, b_out_valid, b_out_data, b_out_last, b_out_err,
                     exp_beat, (idx == B_CH - 1), exp_err);
         end
         b_out_ready = 1'($urandom);
         if (b_out_ready) idx++;
         @(negedge clock);
         cyc++;
      end
      b_out_ready = 1'b0;
      checks++;
      if (idx != B_CH || b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
         errors++;
         $display("FAIL b_post: got beats=%0d v=%b busy=%b want %0d 0 0",
                  idx, b_out_valid, b_busy, B_CH);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      checks++;
      if ({a_in_ready, a_start, a_out_valid, a_out_last, a_out_err, a_busy} !== 6'b100000 ||
          a_op !== '0 || a_operands !== '0 || a_out_data !== '0) begin
         errors++;
         $display("FAIL a_reset: got ir=%b st=%b v=%b l=%b e=%b busy=%b op=%h opnds=%h d=%h",
                  a_in_ready, a_start, a_out_valid, a_out_last, a_out_err, a_busy,
                  a_op, a_operands, a_out_data);
      end
      checks++;
      if ({b_in_ready, b_start, b_out_valid, b_out_last, b_out_err, b_busy} !== 6'b100000 ||
          b_op !== '0 || b_operands !== '0) begin
         errors++;
         $display("FAIL b_reset: got ir=%b st=%b v=%b l=%b e=%b busy=%b op=%h opnds=%h",
                  b_in_ready, b_start, b_out_valid, b_out_last, b_out_err, b_busy,
                  b_op, b_operands);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_directed();
      run_a(4'h3, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_a(4'h3, 32'h3F80_0000, 32'h4000_0000, 3, 32'h4040_0000, 1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      run_a(4'h9, 32'($urandom), 32'($urandom), 0, 32'($urandom), 0, 1'b1, 1'b0);
      run_a(4'h9, 32'($urandom), 32'($urandom), A_TMO, 32'h1234_5678, 2, 1'b1, 1'b0);
      run_a(4'h1, 32'($urandom), 32'($urandom), 1, 32'($urandom), 0, 1'b1, 1'b0);
   endtask

   task automatic test_mid_reset();
      a_in_valid = 1'b1; a_in_data = 12'h005;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         a_in_data = 12'($urandom) | 12'h001;
         @(negedge clock);
      end
      a_in_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({a_in_ready, a_start, a_out_valid, a_out_last, a_out_err, a_busy} !== 6'b100000 ||
          a_op !== '0 || a_operands !== '0) begin
         errors++;
         $display("FAIL mid_reset: got ir=%b st=%b v=%b l=%b e=%b busy=%b op=%h opnds=%h",
                  a_in_ready, a_start, a_out_valid, a_out_last, a_out_err, a_busy,
                  a_op, a_operands);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_a(4'($urandom), 32'($urandom), 32'($urandom), 2, 32'($urandom), 2, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 12; n++) begin
         r = $urandom_range(9, 0);
         run_a(4'($urandom), 32'($urandom), 32'($urandom), (r == 9) ? 100 : r,
               32'($urandom), $urandom_range(2, 0), 1'b1, 1'($urandom));
      end
   endtask

   task automatic test_narrow();
      int r;
      for (int n = 0; n < 6; n++) begin
         r = $urandom_range(5, 1);
         run_b(4'($urandom), 30'($urandom), r, 10'($urandom));
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      clock = 1'b0; reset = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_calc_done = 1'b0; a_calc_result = '0;
      a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_calc_done = 1'b0; b_calc_result = '0;
      b_out_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_timeout();
      test_mid_reset();
      test_random();
      test_narrow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
               checks, errors);
      $fatal(1);
   end

endmodule
